// File: rtl/sc_regserial_pkg.sv
// -----------------------------------------------------------------------------
// sc_regserial_pkg
// Shared definitions for the register serial transmitter slice:
//   - regSerialState_t : FSM state encodings (IDLE / SHIFT / DONE)
//   - RegSERIAL_IDLE_LEVEL : level driven on the serial line when not shifting
//   - regSerialCntWidth() : counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package sc_regserial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } regSerialState_t;

    localparam logic RegSERIAL_IDLE_LEVEL = 1'b0;

    // Bits needed to hold values 0..n-1; a 1-value counter still gets one bit
    // so that every counter has a real declared range.
    function automatic int regSerialCntWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sc_regserial_tx_tick.sv
// -----------------------------------------------------------------------------
// sc_regserial_tick
// Bit-period divider. While enabled it counts clock cycles and raises a
// one-cycle tick on the last cycle of every RegSERIAL_CLKS_PER_BIT period.
// With RegSERIAL_CLKS_PER_BIT = 1 the counter stays at zero, so the tick is
// asserted on every enabled cycle.
//
// Ports:
//   SC_RegGENERAL_CLOCK_50          clock, rising edge
//   SC_RegGENERAL_RESET_InHigh      asynchronous active-high reset
//   SC_RegSERIAL_tickClear_InHigh   synchronous restart of the bit period
//   SC_RegSERIAL_tickEnable_InHigh  count enable (frame being shifted)
//   SC_RegSERIAL_tick_Out           end-of-bit-period strobe
// -----------------------------------------------------------------------------
module sc_regserial_tick
    import sc_regserial_pkg::*;
#(
    parameter int RegSERIAL_CLKS_PER_BIT = 4
) (
    input  logic SC_RegGENERAL_CLOCK_50,
    input  logic SC_RegGENERAL_RESET_InHigh,
    input  logic SC_RegSERIAL_tickClear_InHigh,
    input  logic SC_RegSERIAL_tickEnable_InHigh,
    output logic SC_RegSERIAL_tick_Out
);

    localparam int               CLK_CNT_W = regSerialCntWidth(RegSERIAL_CLKS_PER_BIT);
    localparam logic [CLK_CNT_W-1:0] CLK_LAST = CLK_CNT_W'(RegSERIAL_CLKS_PER_BIT - 1);

    logic [CLK_CNT_W-1:0] clkCntReg;
    logic [CLK_CNT_W-1:0] clkCntNext;

    always_comb begin
        clkCntNext = clkCntReg;
        if (SC_RegSERIAL_tickClear_InHigh) begin
            clkCntNext = '0;
        end else if (SC_RegSERIAL_tickEnable_InHigh) begin
            if (clkCntReg == CLK_LAST) begin
                clkCntNext = '0;
            end else begin
                clkCntNext = clkCntReg + CLK_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            clkCntReg <= '0;
        end else begin
            clkCntReg <= clkCntNext;
        end
    end

    assign SC_RegSERIAL_tick_Out = SC_RegSERIAL_tickEnable_InHigh && (clkCntReg == CLK_LAST);

endmodule

// File: rtl/sc_regserial_tx.sv
// -----------------------------------------------------------------------------
// sc_regserial_tx
// Parallel-in, serial-out transmitter. On an accepted start the word on
// SC_RegSERIAL_data_InBUS is captured and shifted out MSB-first, each bit held
// for RegSERIAL_CLKS_PER_BIT cycles, followed by a one-cycle done pulse.
//
// Optional feature: define SC_REGSERIAL_TX_PARITY_EN to append one even-parity
// bit (XOR of the captured word) after the data bits.
//
// Ports:
//   SC_RegGENERAL_CLOCK_50       clock, rising edge
//   SC_RegGENERAL_RESET_InHigh   asynchronous active-high reset
//   SC_RegSERIAL_start_InHigh    request to send; accepted only while ready
//   SC_RegSERIAL_clear_InHigh    synchronous abort to IDLE (beats start)
//   SC_RegSERIAL_data_InBUS      word to send, sampled on accepted start
//   SC_RegSERIAL_serial_Out      serial line, 0 when not shifting
//   SC_RegSERIAL_ready_Out       high in IDLE
//   SC_RegSERIAL_busy_Out        high in SHIFT
//   SC_RegSERIAL_done_Out        one-cycle pulse after the last bit
// -----------------------------------------------------------------------------
module sc_regserial_tx
    import sc_regserial_pkg::*;
#(
    parameter int RegSERIAL_DATAWIDTH    = 8,
    parameter int RegSERIAL_CLKS_PER_BIT = 4
) (
    input  logic                           SC_RegGENERAL_CLOCK_50,
    input  logic                           SC_RegGENERAL_RESET_InHigh,
    input  logic                           SC_RegSERIAL_start_InHigh,
    input  logic                           SC_RegSERIAL_clear_InHigh,
    input  logic [RegSERIAL_DATAWIDTH-1:0] SC_RegSERIAL_data_InBUS,
    output logic                           SC_RegSERIAL_serial_Out,
    output logic                           SC_RegSERIAL_ready_Out,
    output logic                           SC_RegSERIAL_busy_Out,
    output logic                           SC_RegSERIAL_done_Out
);

`ifdef SC_REGSERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = RegSERIAL_DATAWIDTH + 1;
`else
    localparam int FRAME_BITS = RegSERIAL_DATAWIDTH;
`endif

    localparam int                   BIT_CNT_W = regSerialCntWidth(RegSERIAL_DATAWIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_BITS - 1);

    regSerialState_t       stateReg;
    regSerialState_t       stateNext;
    logic [FRAME_BITS-1:0] shiftReg;
    logic [FRAME_BITS-1:0] shiftNext;
    logic [FRAME_BITS-1:0] frameLoad;
    logic [BIT_CNT_W-1:0]  bitCntReg;
    logic [BIT_CNT_W-1:0]  bitCntNext;
    logic                  accept;
    logic                  lastBit;
    logic                  bitTick;

    // Parity is taken from the word at capture, so later bus changes cannot
    // disturb it.
`ifdef SC_REGSERIAL_TX_PARITY_EN
    assign frameLoad = {SC_RegSERIAL_data_InBUS, ^SC_RegSERIAL_data_InBUS};
`else
    assign frameLoad = SC_RegSERIAL_data_InBUS;
`endif

    assign accept  = (stateReg == IDLE) && SC_RegSERIAL_start_InHigh && !SC_RegSERIAL_clear_InHigh;
    assign lastBit = (bitCntReg == BIT_LAST);

    // The bit period restarts on every accepted start so the first bit gets a
    // full period, and on abort so the next frame starts clean.
    sc_regserial_tick #(
        .RegSERIAL_CLKS_PER_BIT(RegSERIAL_CLKS_PER_BIT)
    ) u_tick (
        .SC_RegGENERAL_CLOCK_50        (SC_RegGENERAL_CLOCK_50),
        .SC_RegGENERAL_RESET_InHigh    (SC_RegGENERAL_RESET_InHigh),
        .SC_RegSERIAL_tickClear_InHigh (SC_RegSERIAL_clear_InHigh || accept),
        .SC_RegSERIAL_tickEnable_InHigh(stateReg == SHIFT),
        .SC_RegSERIAL_tick_Out         (bitTick)
    );

    // State register
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            stateReg  <= IDLE;
            shiftReg  <= '0;
            bitCntReg <= '0;
        end else begin
            stateReg  <= stateNext;
            shiftReg  <= shiftNext;
            bitCntReg <= bitCntNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        if (SC_RegSERIAL_clear_InHigh) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE:    if (SC_RegSERIAL_start_InHigh) stateNext = SHIFT;
                SHIFT:   if (bitTick && lastBit) stateNext = DONE;
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Shift register and bit counter; the final bit is not shifted because
    // the line is forced idle in DONE anyway.
    always_comb begin
        shiftNext  = shiftReg;
        bitCntNext = bitCntReg;
        if (SC_RegSERIAL_clear_InHigh) begin
            shiftNext  = '0;
            bitCntNext = '0;
        end else if (accept) begin
            shiftNext  = frameLoad;
            bitCntNext = '0;
        end else if ((stateReg == SHIFT) && bitTick && !lastBit) begin
            shiftNext  = shiftReg << 1;
            bitCntNext = bitCntReg + BIT_CNT_W'(1);
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        SC_RegSERIAL_serial_Out = RegSERIAL_IDLE_LEVEL;
        SC_RegSERIAL_ready_Out  = 1'b0;
        SC_RegSERIAL_busy_Out   = 1'b0;
        SC_RegSERIAL_done_Out   = 1'b0;
        case (stateReg)
            IDLE:  SC_RegSERIAL_ready_Out = 1'b1;
            SHIFT: begin
                SC_RegSERIAL_busy_Out   = 1'b1;
                SC_RegSERIAL_serial_Out = shiftReg[FRAME_BITS-1];
            end
            DONE:  SC_RegSERIAL_done_Out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sc_regserial_tx.sv
// -----------------------------------------------------------------------------
// tb_sc_regserial_tx
// Directed bench for sc_regserial_tx (DATAWIDTH=8, CLKS_PER_BIT=4). Expected
// serial bits are queued when a start is driven and popped as the line is
// observed. Frame length follows SC_REGSERIAL_TX_PARITY_EN when defined.
// -----------------------------------------------------------------------------
module tb_sc_regserial_tx;

    localparam int DW   = 8;
    localparam int CLKS = 4;
`ifdef SC_REGSERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = DW + 1;
`else
    localparam int FRAME_BITS = DW;
`endif

    localparam int ACT_NONE  = 0;
    localparam int ACT_START = 1;
    localparam int ACT_CLEAR = 2;
    localparam int ACT_RESET = 3;

    logic          clk;
    logic          srst;
    logic          start;
    logic          clear;
    logic [DW-1:0] data;
    logic          serOut;
    logic          ready;
    logic          busy;
    logic          done;

    logic expQ[$];
    int   vectors;
    int   miscompares;

    sc_regserial_tx #(
        .RegSERIAL_DATAWIDTH   (DW),
        .RegSERIAL_CLKS_PER_BIT(CLKS)
    ) dut (
        .SC_RegGENERAL_CLOCK_50    (clk),
        .SC_RegGENERAL_RESET_InHigh(srst),
        .SC_RegSERIAL_start_InHigh (start),
        .SC_RegSERIAL_clear_InHigh (clear),
        .SC_RegSERIAL_data_InBUS   (data),
        .SC_RegSERIAL_serial_Out   (serOut),
        .SC_RegSERIAL_ready_Out    (ready),
        .SC_RegSERIAL_busy_Out     (busy),
        .SC_RegSERIAL_done_Out     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        chk({tag, "_serial"}, serOut, 1'b0);
        chk({tag, "_ready"},  ready,  1'b1);
        chk({tag, "_busy"},   busy,   1'b0);
        chk({tag, "_done"},   done,   1'b0);
    endtask

    task automatic idleNoDone(input int n);
        for (int k = 0; k < n; k++) begin
            checkIdle("idle_after");
            step();
        end
    endtask

    task automatic pushFrame(input logic [DW-1:0] d);
        for (int i = DW - 1; i >= 0; i--) expQ.push_back(d[i]);
`ifdef SC_REGSERIAL_TX_PARITY_EN
        expQ.push_back(^d);
`endif
    endtask

    // Checks one frame starting at the sample just after the accepting edge.
    // Optionally injects an ignored start, a clear or a reset at sample 'at'.
    task automatic frameCheck(input int action, input int at);
        int   cyc;
        logic b;
        cyc = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            chk("scoreboard_nonempty", expQ.size() != 0, 1'b1);
            b = (expQ.size() != 0) ? expQ.pop_front() : 1'b0;
            for (int c = 0; c < CLKS; c++) begin
                if (action == ACT_START && cyc == at) begin
                    start = 1'b1;
                    data  = 8'hFF;
                end else if (action == ACT_START && cyc == at + 1) begin
                    start = 1'b0;
                end
                if (action == ACT_CLEAR && cyc == at) begin
                    clear = 1'b1;
                    step();
                    clear = 1'b0;
                    checkIdle("abort");
                    idleNoDone(6);
                    expQ.delete();
                    return;
                end
                if (action == ACT_RESET && cyc == at) begin
                    #2 srst = 1'b1;
                    #1;
                    checkIdle("async_reset");
                    step();
                    step();
                    srst = 1'b0;
                    idleNoDone(6);
                    expQ.delete();
                    return;
                end
                chk("serial", serOut, b);
                chk("busy",   busy,   1'b1);
                chk("done_early", done, 1'b0);
                step();
                cyc++;
            end
        end
        chk("done_pulse",  done,   1'b1);
        chk("done_serial", serOut, 1'b0);
        chk("done_busy",   busy,   1'b0);
        chk("done_ready",  ready,  1'b0);
        step();
        chk("end_done",  done,  1'b0);
        chk("end_ready", ready, 1'b1);
    endtask

    task automatic sendFrame(input logic [DW-1:0] d, input int action, input int at);
        data  = d;
        start = 1'b1;
        pushFrame(d);
        step();
        start = 1'b0;
        $display("[tb] frame data=%02h action=%0d at=%0d", d, action, at);
        frameCheck(action, at);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        srst  = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        data  = '0;

        #2 srst = 1'b1;
        #1;
        checkIdle("reset");
        step();
        step();
        srst = 1'b0;
        step();
        checkIdle("post_reset");

        sendFrame(8'hA5, ACT_NONE,  -1);
        sendFrame(8'h3C, ACT_START, 10);
        sendFrame(8'h5A, ACT_RESET, 10);
        sendFrame(8'hFF, ACT_CLEAR, 13);
        sendFrame(8'h81, ACT_NONE,  -1);

        // Back-to-back with start held high; data changes after acceptance.
        data  = 8'h01;
        start = 1'b1;
        pushFrame(8'h01);
        step();
        data = 8'h80;
        $display("[tb] frame data=01 back-to-back first");
        frameCheck(ACT_NONE, -1);
        pushFrame(8'h80);
        step();
        start = 1'b0;
        $display("[tb] frame data=80 back-to-back second");
        frameCheck(ACT_NONE, -1);

        // Start and clear together in IDLE: no frame.
        data  = 8'hFF;
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        $display("[tb] start+clear in idle");
        checkIdle("start_clear");
        idleNoDone(4);

        sendFrame(8'h07, ACT_NONE, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
